// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm controller: state encodings, tick rates,
// timer width and the time-match helper.
package alarm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RINGING = 2'd1,
      ST_SNOOZE  = 2'd2,
      ST_ILLEGAL = 2'd3
   } alarm_state_e;

   localparam int unsigned TICKS_PER_SEC      = 32'd100;
   localparam int unsigned TICKS_PER_MIN      = 32'd6000;
   localparam int unsigned BUZZER_HALF_PERIOD = 32'd50;
   localparam int unsigned TIMER_W            = 32'd20;

   // Hours, minutes and AM/PM must agree; seconds and fraction are ignored.
   function automatic logic time_match(input logic [31:0] cur_time,
                                       input logic        cur_pm,
                                       input logic [31:0] alm_time,
                                       input logic        alm_pm);
      return (cur_time[31:16] == alm_time[31:16]) && (cur_pm == alm_pm);
   endfunction

endpackage

// File: rtl/alarm_controller_if.sv
// Bundle of the alarm controller's time, control and status signals.
interface alarm_controller_if;

   logic        i_Tick_10ms;
   logic        i_Alarm_En;
   logic [31:0] i_Current_Time;
   logic        i_Current_PM;
   logic [31:0] i_Alarm_Time;
   logic        i_Alarm_PM;
   logic        i_Snooze;
   logic        i_Stop;
   logic        o_Ringing;
   logic        o_Buzzer;
   logic        o_Snoozing;
   logic [1:0]  o_State;
   logic [1:0]  o_Snooze_Count;

   modport master (
      output i_Tick_10ms, i_Alarm_En, i_Current_Time, i_Current_PM,
             i_Alarm_Time, i_Alarm_PM, i_Snooze, i_Stop,
      input  o_Ringing, o_Buzzer, o_Snoozing, o_State, o_Snooze_Count
   );

   modport slave (
      input  i_Tick_10ms, i_Alarm_En, i_Current_Time, i_Current_PM,
             i_Alarm_Time, i_Alarm_PM, i_Snooze, i_Stop,
      output o_Ringing, o_Buzzer, o_Snoozing, o_State, o_Snooze_Count
   );

endinterface

// File: rtl/alarm_tick_timer.sv
// Tick counter: held at zero by clear, advances on tick, pulses done on the
// tick that reaches last_count and wraps back to zero.
module alarm_tick_timer
   import alarm_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               tick,
   input  logic [TIMER_W-1:0] last_count,
   output logic               done
);

   logic [TIMER_W-1:0] cnt_q;
   logic [TIMER_W-1:0] cnt_d;
   logic               at_end_s;

   always_comb begin
      at_end_s = (cnt_q == last_count);
      done     = tick & at_end_s & ~clear;
      cnt_d    = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (tick) begin
         cnt_d = at_end_s ? '0 : cnt_q + {{(TIMER_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/alarm_controller.sv
// Alarm clock controller: match/trigger detection, ring/snooze FSM, buzzer.
// Build option: ALARM_SNOOZE_LIMIT_EN enforces MAX_SNOOZE snoozes per alarm.
module alarm_controller
   import alarm_pkg::*;
#(
   parameter int unsigned RING_TIMEOUT_S = 32'd60,
   parameter int unsigned SNOOZE_MIN     = 32'd9,
   parameter int unsigned MAX_SNOOZE     = 32'd3
) (
   input logic               i_Clk_5MHz,
   input logic               i_Reset,
   alarm_controller_if.slave bus
);

   localparam logic [TIMER_W-1:0] RING_LAST   = TIMER_W'(RING_TIMEOUT_S * TICKS_PER_SEC - 32'd1);
   localparam logic [TIMER_W-1:0] SNOOZE_LAST = TIMER_W'(SNOOZE_MIN * TICKS_PER_MIN - 32'd1);
   localparam logic [TIMER_W-1:0] BUZZ_LAST   = TIMER_W'(BUZZER_HALF_PERIOD - 32'd1);
`ifdef ALARM_SNOOZE_LIMIT_EN
   localparam bit SNOOZE_LIMITED = 1'b1;
`else
   localparam bit SNOOZE_LIMITED = 1'b0;
`endif

   alarm_state_e state_q, state_d, fsm_state_s;
   logic [1:0]   count_q, count_d, fsm_count_s;
   logic         match_q, match_d;
   logic         ringing_q, ringing_d;
   logic         buzzer_q, buzzer_d;
   logic         snoozing_q, snoozing_d;
   logic         match_s, trigger_s, snooze_ok_s;
   logic         ring_clear_s, snooze_clear_s;
   logic         ring_done_s, snooze_done_s, buzz_done_s;

   assign ring_clear_s   = (state_q != ST_RINGING) | ~bus.i_Alarm_En;
   assign snooze_clear_s = (state_q != ST_SNOOZE) | ~bus.i_Alarm_En;

   alarm_tick_timer u_ring_timer (
      .clk(i_Clk_5MHz), .rst(i_Reset), .clear(ring_clear_s),
      .tick(bus.i_Tick_10ms), .last_count(RING_LAST), .done(ring_done_s)
   );

   alarm_tick_timer u_snooze_timer (
      .clk(i_Clk_5MHz), .rst(i_Reset), .clear(snooze_clear_s),
      .tick(bus.i_Tick_10ms), .last_count(SNOOZE_LAST), .done(snooze_done_s)
   );

   alarm_tick_timer u_buzz_timer (
      .clk(i_Clk_5MHz), .rst(i_Reset), .clear(ring_clear_s),
      .tick(bus.i_Tick_10ms), .last_count(BUZZ_LAST), .done(buzz_done_s)
   );

   always_comb begin
      match_s     = time_match(bus.i_Current_Time, bus.i_Current_PM,
                               bus.i_Alarm_Time, bus.i_Alarm_PM);
      match_d     = match_s;
      trigger_s   = match_s & ~match_q;
      snooze_ok_s = !SNOOZE_LIMITED || ({30'd0, count_q} < MAX_SNOOZE);
      fsm_state_s = state_q;
      fsm_count_s = count_q;

      // Stop outranks snooze; a refused snooze behaves exactly like stop.
      case (state_q)
         ST_IDLE: begin
            fsm_state_s = trigger_s ? ST_RINGING : ST_IDLE;
            fsm_count_s = 2'd0;
         end
         ST_RINGING: begin
            if (bus.i_Stop) begin
               fsm_state_s = ST_IDLE;
               fsm_count_s = 2'd0;
            end else if (bus.i_Snooze && snooze_ok_s) begin
               fsm_state_s = ST_SNOOZE;
               fsm_count_s = (count_q == 2'd3) ? 2'd3 : count_q + 2'd1;
            end else if (bus.i_Snooze || ring_done_s) begin
               fsm_state_s = ST_IDLE;
               fsm_count_s = 2'd0;
            end else begin
               fsm_state_s = ST_RINGING;
               fsm_count_s = count_q;
            end
         end
         ST_SNOOZE: begin
            if (bus.i_Stop) begin
               fsm_state_s = ST_IDLE;
               fsm_count_s = 2'd0;
            end else if (snooze_done_s) begin
               fsm_state_s = ST_RINGING;
               fsm_count_s = count_q;
            end else begin
               fsm_state_s = ST_SNOOZE;
               fsm_count_s = count_q;
            end
         end
         default: begin
            fsm_state_s = ST_IDLE;
            fsm_count_s = 2'd0;
         end
      endcase

      state_d    = bus.i_Alarm_En ? fsm_state_s : ST_IDLE;
      count_d    = bus.i_Alarm_En ? fsm_count_s : 2'd0;
      ringing_d  = (state_d == ST_RINGING);
      snoozing_d = (state_d == ST_SNOOZE);

      if (state_d != ST_RINGING) begin
         buzzer_d = 1'b0;
      end else if (state_q != ST_RINGING) begin
         buzzer_d = 1'b1;
      end else if (buzz_done_s) begin
         buzzer_d = ~buzzer_q;
      end else begin
         buzzer_d = buzzer_q;
      end
   end

   // Match resets high so releasing reset while already matching does not ring.
   always_ff @(posedge i_Clk_5MHz or posedge i_Reset) begin
      if (i_Reset) begin
         state_q    <= ST_IDLE;
         count_q    <= 2'd0;
         match_q    <= 1'b1;
         ringing_q  <= 1'b0;
         buzzer_q   <= 1'b0;
         snoozing_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         match_q    <= match_d;
         ringing_q  <= ringing_d;
         buzzer_q   <= buzzer_d;
         snoozing_q <= snoozing_d;
      end
   end

   assign bus.o_State        = state_q;
   assign bus.o_Snooze_Count = count_q;
   assign bus.o_Ringing      = ringing_q;
   assign bus.o_Buzzer       = buzzer_q;
   assign bus.o_Snoozing     = snoozing_q;

endmodule
